// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single Hack data memory between requester A
// (CPU data port) and requester B (DMA / screen-fill engine).
// Each transaction runs IDLE -> ACCESS -> RESP. Writes at or above KBD_BASE
// are dropped and reported on prot_err.
// Optional build macro MEM_ARB_PRIO_A_EN: when defined, A wins ties except
// that B is forced through after 15 consecutive lost ties. When undefined,
// ties are resolved round-robin.
module mem_arbiter #(
  parameter int                ADDR_W   = 15,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] KBD_BASE = 'h6000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_out,
  output logic              prot_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;

  // Latched transaction fields; gnt_b_q = 1 means B owns the transaction
  logic                gnt_b_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                prot_q;
  logic [DATA_W-1:0]   a_rdata_q;
  logic [DATA_W-1:0]   b_rdata_q;

  logic                any_req;
  logic                grant_b;
  logic                take;

  assign any_req = a_req | b_req;
  assign take    = (state_q == S_IDLE) && any_req;

`ifdef MEM_ARB_PRIO_A_EN
  logic [3:0]          starve_q;

  // Winner select: A by default, B alone or after 15 consecutive lost ties
  always_comb begin
    grant_b = 1'b0;
    if (b_req && !a_req) begin
      grant_b = 1'b1;
    end else if (a_req && b_req) begin
      grant_b = (starve_q == 4'd15);
    end
  end

  // Starvation counter: counts IDLE grants that B lost, clears when B wins
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= 4'd0;
    end else if (take) begin
      if (grant_b) begin
        starve_q <= 4'd0;
      end else if (b_req) begin
        starve_q <= starve_q + 4'd1;
      end
    end
  end
`else
  logic                last_b_q;

  // Winner select: a lone requester wins, ties go to whoever was not last
  always_comb begin
    grant_b = 1'b0;
    if (b_req && !a_req) begin
      grant_b = 1'b1;
    end else if (a_req && b_req) begin
      grant_b = ~last_b_q;
    end
  end

  // Last-grant memory for round-robin; resets to B so A wins the first tie
  always_ff @(posedge clock) begin
    if (reset) begin
      last_b_q <= 1'b1;
    end else if (take) begin
      last_b_q <= grant_b;
    end
  end
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; requests during RESP are deliberately ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (any_req) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs: write strobe only in ACCESS below KBD_BASE, acks only in RESP
  always_comb begin
    mem_write = 1'b0;
    a_ack     = 1'b0;
    b_ack     = 1'b0;
    prot_err  = 1'b0;
    if (!reset) begin
      if (state_q == S_ACCESS) begin
        mem_write = we_q && (addr_q < KBD_BASE);
      end
      if (state_q == S_RESP) begin
        a_ack    = ~gnt_b_q;
        b_ack    = gnt_b_q;
        prot_err = prot_q;
      end
    end
  end

  // Datapath: latch the winner in IDLE, capture read data / protection at end of ACCESS
  always_ff @(posedge clock) begin
    if (reset) begin
      gnt_b_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      prot_q    <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (take) begin
        gnt_b_q <= grant_b;
        we_q    <= grant_b ? b_we    : a_we;
        addr_q  <= grant_b ? b_addr  : a_addr;
        wdata_q <= grant_b ? b_wdata : a_wdata;
      end
      if (state_q == S_ACCESS) begin
        prot_q <= we_q && (addr_q >= KBD_BASE);
        if (gnt_b_q) begin
          b_rdata_q <= mem_out;
        end else begin
          a_rdata_q <= mem_out;
        end
      end
    end
  end

  // Memory address/data hold the latched values between transactions
  assign mem_addr = addr_q;
  assign mem_in   = wdata_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter with a small
// behavioural model of the Hack data memory (combinational read, write on
// the rising edge).
module tb_mem_arbiter;

  localparam int AW = 15;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ack, b_ack;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_in;
  logic          mem_write;
  logic [DW-1:0] mem_out;
  logic          prot_err;

  int tests = 0;
  int fails = 0;

  mem_arbiter dut (
    .clock    (clock),
    .reset    (reset),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_ack    (a_ack),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_ack    (b_ack),
    .b_rdata  (b_rdata),
    .mem_addr (mem_addr),
    .mem_in   (mem_in),
    .mem_write(mem_write),
    .mem_out  (mem_out),
    .prot_err (prot_err)
  );

  always #5 clock = ~clock;

  // Memory model: words never written return a fixed preload pattern
  bit [DW-1:0] mem_q [0:(1<<AW)-1];
  bit          wv_q  [0:(1<<AW)-1];

  function automatic logic [DW-1:0] preload(input logic [AW-1:0] a);
    case (a)
      15'h0010: preload = 16'h1234;
      15'h6000: preload = 16'h0042;
      15'h7FFF: preload = 16'h7777;
      default:  preload = 16'h0000;
    endcase
  endfunction

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    mem_word = wv_q[a] ? mem_q[a] : preload(a);
  endfunction

  always @(posedge clock) begin
    if (mem_write) begin
      mem_q[mem_addr] <= mem_in;
      wv_q[mem_addr]  <= 1'b1;
    end
  end

  always_comb mem_out = mem_word(mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit            is_b;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            chk_rd;
    logic [DW-1:0] exp_rd;
    int            exp_wr;
    bit            exp_prot;
  } vec_t;

  // One single-requester transaction; checks latency, write strobes, prot_err, rdata
  task automatic run_txn(input vec_t v, input int idx);
    int            ack_cyc;
    int            prot_cyc;
    int            wr;
    int            other;
    logic          own;
    logic          oth;
    logic [DW-1:0] rd;
    string         tag;
    ack_cyc  = -1;
    prot_cyc = -1;
    wr       = 0;
    other    = 0;
    rd       = '0;
    tag      = $sformatf("v%0d", idx);
    @(negedge clock);
    if (v.is_b) begin
      b_req = 1'b1; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata;
    end else begin
      a_req = 1'b1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata;
    end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clock);
      #1;
      if (mem_write) wr++;
      if (prot_err && prot_cyc < 0) prot_cyc = k;
      own = v.is_b ? b_ack : a_ack;
      oth = v.is_b ? a_ack : b_ack;
      if (oth) other++;
      if (own && ack_cyc < 0) begin
        ack_cyc = k;
        rd      = v.is_b ? b_rdata : a_rdata;
        a_req   = 1'b0;
        b_req   = 1'b0;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    check({tag, "_ack_latency"}, ack_cyc, 2);
    check({tag, "_write_count"}, wr, v.exp_wr);
    check({tag, "_prot_cycle"}, prot_cyc, v.exp_prot ? 2 : -1);
    check({tag, "_other_ack"}, other, 0);
    if (v.chk_rd) check({tag, "_rdata"}, rd, v.exp_rd);
  endtask

  vec_t vecs[9];

  initial begin
    int a_first, b_first, a_second, a_before_b, bad;
    int acks, wr;

    vecs[0] = '{is_b:0, we:0, addr:15'h0010, wdata:16'h0000, chk_rd:1, exp_rd:16'h1234, exp_wr:0, exp_prot:0};
    vecs[1] = '{is_b:1, we:1, addr:15'h4005, wdata:16'hBEEF, chk_rd:0, exp_rd:16'h0000, exp_wr:1, exp_prot:0};
    vecs[2] = '{is_b:1, we:0, addr:15'h4005, wdata:16'h0000, chk_rd:1, exp_rd:16'hBEEF, exp_wr:0, exp_prot:0};
    vecs[3] = '{is_b:0, we:1, addr:15'h6000, wdata:16'hFFFF, chk_rd:0, exp_rd:16'h0000, exp_wr:0, exp_prot:1};
    vecs[4] = '{is_b:0, we:0, addr:15'h6000, wdata:16'h0000, chk_rd:1, exp_rd:16'h0042, exp_wr:0, exp_prot:0};
    vecs[5] = '{is_b:0, we:1, addr:15'h7FFF, wdata:16'h1111, chk_rd:0, exp_rd:16'h0000, exp_wr:0, exp_prot:1};
    vecs[6] = '{is_b:1, we:0, addr:15'h7FFF, wdata:16'h0000, chk_rd:1, exp_rd:16'h7777, exp_wr:0, exp_prot:0};
    vecs[7] = '{is_b:0, we:1, addr:15'h5FFF, wdata:16'hA5A5, chk_rd:0, exp_rd:16'h0000, exp_wr:1, exp_prot:0};
    vecs[8] = '{is_b:0, we:0, addr:15'h5FFF, wdata:16'h0000, chk_rd:1, exp_rd:16'hA5A5, exp_wr:0, exp_prot:0};

    reset = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_a_ack", a_ack, 0);
    check("rst_b_ack", b_ack, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_prot_err", prot_err, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_in", mem_in, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_b_rdata", b_rdata, 0);

    // Tie from reset release: both requesters hold req continuously
    @(negedge clock);
    a_req = 1'b1; a_we = 1'b0; a_addr = 15'h0010;
    b_req = 1'b1; b_we = 1'b0; b_addr = 15'h0020;
    @(negedge clock);
    reset = 1'b0;
    a_first = -1; b_first = -1; a_second = -1; a_before_b = 0;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clock);
      #1;
      if (a_ack) begin
        if (a_first < 0) a_first = k;
        else if (a_second < 0) a_second = k;
        if (b_first < 0) a_before_b++;
      end
      if (b_ack && b_first < 0) b_first = k;
    end
    check("tie_first_a_ack", a_first, 2);
`ifdef MEM_ARB_PRIO_A_EN
    check("tie_b_after_15_losses", b_first, 47);
    check("tie_a_wins_before_b", a_before_b, 15);
`else
    check("tie_b_ack", b_first, 5);
    check("tie_second_a_ack", a_second, 8);
    check("tie_a_wins_before_b", a_before_b, 1);
`endif
    @(negedge clock);
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (4) @(posedge clock);

    for (int i = 0; i < 9; i++) run_txn(vecs[i], i);

    // Idle hold after the last transaction (read of 0x5FFF)
    bad = 0;
    acks = 0;
    wr = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      if (mem_write) wr++;
      if (a_ack || b_ack) acks++;
      if (mem_addr !== 15'h5FFF) bad++;
    end
    check("idle_mem_write", wr, 0);
    check("idle_acks", acks, 0);
    check("idle_addr_hold_errors", bad, 0);

    // Reset asserted while a write to 0x0001 is in ACCESS
    @(negedge clock);
    a_req = 1'b1; a_we = 1'b1; a_addr = 15'h0001; a_wdata = 16'h5555;
    @(posedge clock);
    #1;
    reset = 1'b1;
    a_req = 1'b0;
    #1;
    check("rstacc_mem_write_gated", mem_write, 0);
    acks = 0;
    wr = 0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clock);
      #1;
      if (k == 2) reset = 1'b0;
      if (mem_write) wr++;
      if (a_ack || b_ack) acks++;
    end
    check("rstacc_no_write", wr, 0);
    check("rstacc_no_ack", acks, 0);
    check("rstacc_mem_unchanged", mem_word(15'h0001), 16'h0000);
    run_txn('{is_b:0, we:0, addr:15'h0001, wdata:16'h0000, chk_rd:1, exp_rd:16'h0000, exp_wr:0, exp_prot:0}, 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
